muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle HI/LO multiply/divide controller in the EX stage. It accepts the multiply-class operations the decoder flags (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL, MTHI, MTLO, MFHI, MFLO, optionally DIV/DIVU). It sequences a 32-iteration radix-2 shift-add/shift-subtract datapath and owns the HI/LO registers. It stalls the pipeline whenever a HI/LO consumer or new operation arrives while an operation is still in flight.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req  in  1  operation valid from EX, held by the pipeline while `stall` is high.
- mul_op  in  1  decoder MULOp; 1 = SPECIAL2 function space, 0 = SPECIAL.
- func  in  6  decoder Func (MIPS function code).
- a, b  in  32 each  rs and rt operand values.
- flush  in  1  aborts any in-flight operation.
- stall  out  1  pipeline hold request.
- busy  out  1  high when the FSM is not IDLE.
- hi, lo  out  32 each  architectural HI/LO; drive MFHI/MFLO combinationally.
- mul_result  out  32  low word of the MUL product.
- result_valid  out  1  one-cycle pulse when `mul_result` is valid for write-back.

## Operation
- Reset values: hi = 0, lo = 0, mul_result = 0, result_valid = 0, busy = 0, stall = 0, FSM in IDLE.
- An operation is accepted on any edge with req && !busy && !flush.
- Decode of accepted operations:
  - MTHI (SPECIAL 0x11): hi <= a, single cycle.
  - MTLO (SPECIAL 0x13): lo <= a, single cycle.
  - MFHI (0x10) and MFLO (0x12): no state change.
  - MULT (0x18), MULTU (0x19), DIV (0x1A), DIVU (0x1B): start the FSM.
  - MADD (SPECIAL2 0x00), MADDU (0x01), MUL (0x02), MSUB (0x04), MSUBU (0x05): start the FSM.
  - Any other func: ignored.
- FSM states and transitions:
  - IDLE → MUL or DIV on accept. Operand magnitudes are latched (absolute value for signed ops), sign flags are latched, cnt = 0.
  - MUL: one shift-add iteration per cycle, cnt++. After cnt = 31 completes, go to FIX.
  - DIV: one restoring shift-subtract iteration per cycle. After 32 iterations, go to FIX.
  - FIX: apply sign correction and accumulation, write results, return to IDLE.
- Signed multiply: the 64-bit product is negated if the operand signs differ.
- MADD/MADDU: {hi,lo} <= {hi,lo} + product, computed modulo 2^64.
- MSUB/MSUBU: {hi,lo} <= {hi,lo} − product, computed modulo 2^64.
- MULT/MULTU: {hi,lo} <= product.
- MUL: mul_result <= product[31:0] and result_valid pulses; HI/LO are unchanged.
- Signed divide: quotient is negated if the signs differ; remainder takes the sign of the dividend. lo <= quotient, hi <= remainder.
- 0x80000000 / −1 gives lo = 0x80000000, hi = 0.
- Divide by zero (signed or unsigned): lo = 0xFFFFFFFF, hi = a unchanged. No sign correction is applied.
- stall = req && busy && (op is MFHI, MFLO, MTHI, MTLO, or any FSM-starting op). Non-HI/LO requests never stall.
- flush forces IDLE on the next edge, discards the partial result, and leaves HI/LO unchanged. No result_valid is produced.
- flush and req on the same edge: flush wins and the op is not accepted.
- nrst asserted mid-operation: immediate return to reset values.

## Timing
- Accept at edge E0. busy is high from E0 through E33 inclusive.
- MUL/DIV iterations occur on edges E1..E32. FIX occurs on E33.
- HI/LO or mul_result is updated at E33; result_valid is high in the cycle after E33.
- A dependent MFHI presented at E1 stalls until E33 and completes reading the new HI in the cycle after E33.
- Back-to-back accept is allowed: a new op can be accepted at E34, giving a throughput of one FSM op per 34 cycles.
- MTHI/MTLO take effect at the accepting edge; an MFHI in the next cycle reads the new value.

## Configuration
- Macro `MULDIV_DIV_EN`.
- Defined: DIV/DIVU, the DIV state and the restoring-division datapath are compiled in.
- Undefined:
  - func 0x1A/0x1B is treated as an ignored op: no stall, no busy, HI/LO unchanged.
  - The DIV state and divider logic are absent.

## Structure
- `muldiv_pkg` holds:
  - the state enum {IDLE, MUL, DIV, FIX};
  - localparams for every func code listed above;
  - the 64-bit accumulator type.
- One sub-module, `muldiv_step`, is natural. It is combinational and computes one iteration (shift-add or shift-subtract) from {acc, operand, mode}.
- `muldiv_ctrl` owns the FSM, the counter, the sign handling, the FIX-stage accumulation and the HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 33 cycles.
- MTHI a=1, MTLO a=0xFFFFFFFF, then MADDU a=1, b=1 → hi=2, lo=0 (carry across words).
- MUL a=7, b=6 issued, then MFLO presented next cycle → stall held for 32 cycles; mul_result=42 with a one-cycle result_valid; HI/LO unchanged.
- With MULTU a=0xFFFFFFFF, b=0xFFFFFFFF in flight, assert flush at E10 → busy drops next cycle and HI/LO keep their prior values; a new MULTU accepted at E12 completes normally (hi=0xFFFFFFFE, lo=1).
- With `MULDIV_DIV_EN`:
  - DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
  - Without the macro, the same requests leave HI/LO untouched and busy=0.
- nrst pulsed mid-MSUB → all outputs return to reset values asynchronously; a subsequent MSUB of a=2, b=3 gives {hi,lo}=0xFFFFFFFF_FFFFFFFA.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the HI/LO multiply/divide
//               controller: FSM state encoding, MIPS function codes, the
//               operation-kind tags latched at accept, the 64-bit
//               accumulator type and an operand-magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Iteration accumulator: {upper partial, lower shifting word}
    typedef logic [63:0] acc_t;

    // SPECIAL function space (mul_op = 0)
    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MTHI  = 6'h11;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MTLO  = 6'h13;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;

    // SPECIAL2 function space (mul_op = 1)
    localparam logic [5:0] c_FN_MADD  = 6'h00;
    localparam logic [5:0] c_FN_MADDU = 6'h01;
    localparam logic [5:0] c_FN_MUL   = 6'h02;
    localparam logic [5:0] c_FN_MSUB  = 6'h04;
    localparam logic [5:0] c_FN_MSUBU = 6'h05;

    // What the FIX stage does with the finished accumulator
    localparam logic [2:0] c_KIND_MULT = 3'd0;  // {hi,lo} <= product
    localparam logic [2:0] c_KIND_MADD = 3'd1;  // {hi,lo} += product
    localparam logic [2:0] c_KIND_MSUB = 3'd2;  // {hi,lo} -= product
    localparam logic [2:0] c_KIND_MUL  = 3'd3;  // mul_result <= product[31:0]
    localparam logic [2:0] c_KIND_DIV  = 3'd4;  // lo <= quotient, hi <= remainder

    // Absolute value for signed operations, pass-through for unsigned ones
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration of the multiply/divide datapath.
//               mode = 0 : shift-add multiply step on {partial, multiplier}.
//               mode = 1 : restoring shift-subtract divide step on
//                          {remainder, dividend/quotient}.
//               The divide step is built only when MULDIV_DIV_EN is defined;
//               otherwise mode = 1 simply holds the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  acc_t        acc,
    input  logic [31:0] operand,
    input  logic        mode,
    output acc_t        acc_next
);

    logic [32:0] w_sum;
    acc_t        w_mul_next;
`ifdef MULDIV_DIV_EN
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    acc_t        w_div_next;
`endif

    // Multiply: conditionally add the multiplicand to the upper half, then shift right
    always_comb begin
        w_sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        w_mul_next = {w_sum, acc[31:1]};
    end

`ifdef MULDIV_DIV_EN
    // Divide: shift the next dividend bit into the remainder, subtract if it fits
    always_comb begin
        w_rem_sh = acc[63:31];
        w_diff   = w_rem_sh - {1'b0, operand};
        if (!w_diff[32]) begin
            w_div_next = {w_diff[31:0], acc[30:0], 1'b1};
        end else begin
            w_div_next = {w_rem_sh[31:0], acc[30:0], 1'b0};
        end
    end

    assign acc_next = mode ? w_div_next : w_mul_next;
`else
    assign acc_next = mode ? acc : w_mul_next;
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle HI/LO multiply/divide controller (EX stage).
//               Decodes multiply-class ops, runs a 32-iteration radix-2
//               datapath (muldiv_step), applies sign correction and
//               accumulation in FIX, owns HI/LO and requests pipeline stalls
//               for HI/LO consumers arriving while an op is in flight.
//               Optional divide support: define MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        req,
    input  logic        mul_op,
    input  logic [5:0]  func,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mul_result,
    output logic        result_valid
);

    localparam logic [1:0] c_ST_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] c_ST_MUL  = 2'(ST_MUL);
    localparam logic [1:0] c_ST_DIV  = 2'(ST_DIV);
    localparam logic [1:0] c_ST_FIX  = 2'(ST_FIX);

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    acc_t        r_acc;
    logic [31:0] r_opd;
    logic        r_neg;
    logic [2:0]  r_kind;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mul_result;
    logic        r_valid;
`ifdef MULDIV_DIV_EN
    logic        r_rem_neg;
    logic        r_div0;
    logic [31:0] r_dividend;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
`endif

    logic        w_is_mthi;
    logic        w_is_mtlo;
    logic        w_is_mfx;
    logic        w_fsm_op;
    logic        w_signed;
    logic        w_is_div;
    logic [2:0]  w_kind;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_accept;
    acc_t        w_step_acc;
    acc_t        w_prod;
    acc_t        w_hilo;

    // Decode the requested op into HI/LO-move, FSM-start and kind/sign flags
    always_comb begin
        w_is_mthi = 1'b0;
        w_is_mtlo = 1'b0;
        w_is_mfx  = 1'b0;
        w_fsm_op  = 1'b0;
        w_signed  = 1'b0;
        w_kind    = c_KIND_MULT;
        if (!mul_op) begin
            case (func)
                c_FN_MTHI:  w_is_mthi = 1'b1;
                c_FN_MTLO:  w_is_mtlo = 1'b1;
                c_FN_MFHI:  w_is_mfx  = 1'b1;
                c_FN_MFLO:  w_is_mfx  = 1'b1;
                c_FN_MULT:  begin w_fsm_op = 1'b1; w_signed = 1'b1; w_kind = c_KIND_MULT; end
                c_FN_MULTU: begin w_fsm_op = 1'b1; w_kind = c_KIND_MULT; end
`ifdef MULDIV_DIV_EN
                c_FN_DIV:   begin w_fsm_op = 1'b1; w_signed = 1'b1; w_kind = c_KIND_DIV; end
                c_FN_DIVU:  begin w_fsm_op = 1'b1; w_kind = c_KIND_DIV; end
`endif
                default:    ;
            endcase
        end else begin
            case (func)
                c_FN_MADD:  begin w_fsm_op = 1'b1; w_signed = 1'b1; w_kind = c_KIND_MADD; end
                c_FN_MADDU: begin w_fsm_op = 1'b1; w_kind = c_KIND_MADD; end
                c_FN_MUL:   begin w_fsm_op = 1'b1; w_signed = 1'b1; w_kind = c_KIND_MUL; end
                c_FN_MSUB:  begin w_fsm_op = 1'b1; w_signed = 1'b1; w_kind = c_KIND_MSUB; end
                c_FN_MSUBU: begin w_fsm_op = 1'b1; w_kind = c_KIND_MSUB; end
                default:    ;
            endcase
        end
    end

    assign w_is_div = (w_kind == c_KIND_DIV);
    assign w_mag_a  = magnitude(a, w_signed);
    assign w_mag_b  = magnitude(b, w_signed);
    assign w_accept = req && !busy && !flush;

    muldiv_step u_step (
        .acc      (r_acc),
        .operand  (r_opd),
        .mode     (r_state == c_ST_DIV),
        .acc_next (w_step_acc)
    );

    // Sign-corrected product and current HI/LO pair for the FIX stage
    assign w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
    assign w_hilo = {r_hi, r_lo};

`ifdef MULDIV_DIV_EN
    // Quotient negated on sign mismatch; remainder follows the dividend's sign
    assign w_quot = r_neg     ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0];
    assign w_rem  = r_rem_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
`endif

    // FSM, iteration counter, operand latches and HI/LO/result registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 5'd0;
            r_acc        <= '0;
            r_opd        <= 32'd0;
            r_neg        <= 1'b0;
            r_kind       <= c_KIND_MULT;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_mul_result <= 32'd0;
            r_valid      <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_rem_neg    <= 1'b0;
            r_div0       <= 1'b0;
            r_dividend   <= 32'd0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (flush) begin
                // Abort: partial result is simply abandoned
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_accept) begin
                            if (w_is_mthi) r_hi <= a;
                            if (w_is_mtlo) r_lo <= a;
                            if (w_fsm_op) begin
                                r_state <= w_is_div ? c_ST_DIV : c_ST_MUL;
                                r_cnt   <= 5'd0;
                                r_kind  <= w_kind;
                                r_neg   <= w_signed && (a[31] ^ b[31]);
                                // Divide shifts the dividend out of the low word;
                                // multiply shifts the multiplier out of it.
                                r_acc   <= w_is_div ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
                                r_opd   <= w_is_div ? w_mag_b : w_mag_a;
`ifdef MULDIV_DIV_EN
                                r_rem_neg  <= w_signed && a[31];
                                r_div0     <= (b == 32'd0);
                                r_dividend <= a;
`endif
                            end
                        end
                    end
                    c_ST_MUL: begin
                        r_acc <= w_step_acc;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_state <= c_ST_FIX;
                    end
`ifdef MULDIV_DIV_EN
                    c_ST_DIV: begin
                        r_acc <= w_step_acc;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_state <= c_ST_FIX;
                    end
`endif
                    c_ST_FIX: begin
                        r_state <= c_ST_IDLE;
                        case (r_kind)
                            c_KIND_MULT: {r_hi, r_lo} <= w_prod;
                            c_KIND_MADD: {r_hi, r_lo} <= w_hilo + w_prod;
                            c_KIND_MSUB: {r_hi, r_lo} <= w_hilo - w_prod;
                            c_KIND_MUL: begin
                                r_mul_result <= w_prod[31:0];
                                r_valid      <= 1'b1;
                            end
`ifdef MULDIV_DIV_EN
                            c_KIND_DIV: begin
                                if (r_div0) begin
                                    r_lo <= 32'hFFFF_FFFF;
                                    r_hi <= r_dividend;
                                end else begin
                                    r_lo <= w_quot;
                                    r_hi <= w_rem;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign busy         = (r_state != c_ST_IDLE);
    assign stall        = req && busy && (w_is_mthi || w_is_mtlo || w_is_mfx || w_fsm_op);
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign mul_result   = r_mul_result;
    assign result_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl. A behavioural model of
//               HI/LO built from plain 64-bit arithmetic predicts every
//               result; directed vectors plus $urandom operand streams.
//               Divide expectations follow MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        nrst   = 1'b1;
    logic        req    = 1'b0;
    logic        mul_op = 1'b0;
    logic        flush  = 1'b0;
    logic [5:0]  func   = 6'h3F;
    logic [31:0] a      = 32'd0;
    logic [31:0] b      = 32'd0;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_result;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;
    logic [31:0] m_res = 32'd0;
    bit          m_fsm;
    bit          m_valid;

    muldiv_ctrl dut (
        .clk          (clk),
        .nrst         (nrst),
        .req          (req),
        .mul_op       (mul_op),
        .func         (func),
        .a            (a),
        .b            (b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo),
        .mul_result   (mul_result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Architectural effect of one accepted op, from plain integer arithmetic
    function automatic void model_op(input logic mo, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        logic [63:0] acc;
        sp  = longint'($signed(x)) * longint'($signed(y));
        up  = {32'd0, x} * {32'd0, y};
        acc = {m_hi, m_lo};
        m_fsm   = 1'b0;
        m_valid = 1'b0;
        if (!mo) begin
            case (f)
                6'h11: m_hi = x;
                6'h13: m_lo = x;
                6'h18: begin m_fsm = 1'b1; {m_hi, m_lo} = sp; end
                6'h19: begin m_fsm = 1'b1; {m_hi, m_lo} = up; end
                6'h1A: if (DIV_EN) begin
                    m_fsm = 1'b1;
                    if (y == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = x; end
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
                    else begin m_lo = $signed(x) / $signed(y); m_hi = $signed(x) % $signed(y); end
                end
                6'h1B: if (DIV_EN) begin
                    m_fsm = 1'b1;
                    if (y == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = x; end
                    else begin m_lo = x / y; m_hi = x % y; end
                end
                default: ;
            endcase
        end else begin
            case (f)
                6'h00: begin m_fsm = 1'b1; {m_hi, m_lo} = acc + 64'(sp); end
                6'h01: begin m_fsm = 1'b1; {m_hi, m_lo} = acc + up; end
                6'h02: begin m_fsm = 1'b1; m_valid = 1'b1; m_res = sp[31:0]; end
                6'h04: begin m_fsm = 1'b1; {m_hi, m_lo} = acc - 64'(sp); end
                6'h05: begin m_fsm = 1'b1; {m_hi, m_lo} = acc - up; end
                default: ;
            endcase
        end
    endfunction

    // Present one op for a single accepting edge, then observe a 40-cycle window
    task automatic do_op(input logic mo, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                         output int bcyc, output int vcnt, output logic [31:0] vres);
        @(negedge clk);
        req = 1'b1; mul_op = mo; func = f; a = x; b = y;
        @(posedge clk);
        #1;
        req  = 1'b0;
        bcyc = 0;
        vcnt = 0;
        vres = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (result_valid) begin vcnt++; vres = mul_result; end
        end
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        #12;
        checks++; if (hi !== 32'd0)         begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)         begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (mul_result !== 32'd0) begin errors++; $display("FAIL reset_mul_result: got %h want 0", mul_result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_vectors();
        int bc, vc; logic [31:0] vr;
        // MULT -2 * 3
        model_op(1'b0, 6'h18, 32'hFFFF_FFFE, 32'd3);
        do_op(1'b0, 6'h18, 32'hFFFF_FFFE, 32'd3, bc, vc, vr);
        checks++; if (bc !== 33)   begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL mult_hi: got %h want %h", hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL mult_lo: got %h want %h", lo, m_lo); end
        // MTHI visible in the very next cycle
        model_op(1'b0, 6'h11, 32'd1, 32'd0);
        @(negedge clk); req = 1'b1; mul_op = 1'b0; func = 6'h11; a = 32'd1;
        @(posedge clk); #1; req = 1'b0;
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL mthi_next_cycle: got %h want %h", hi, m_hi); end
        // MTLO then MADDU carrying across the word boundary
        model_op(1'b0, 6'h13, 32'hFFFF_FFFF, 32'd0);
        do_op(1'b0, 6'h13, 32'hFFFF_FFFF, 32'd0, bc, vc, vr);
        checks++; if (bc !== 0) begin errors++; $display("FAIL mtlo_busy: got %0d want 0", bc); end
        model_op(1'b1, 6'h01, 32'd1, 32'd1);
        do_op(1'b1, 6'h01, 32'd1, 32'd1, bc, vc, vr);
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL maddu_carry_hi: got %h want %h", hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL maddu_carry_lo: got %h want %h", lo, m_lo); end
    endtask

    task automatic test_stall();
        int nstall, vcnt, n; logic [31:0] vres;
        model_op(1'b1, 6'h02, 32'd7, 32'd6);
        @(negedge clk); req = 1'b1; mul_op = 1'b1; func = 6'h02; a = 32'd7; b = 32'd6;
        @(posedge clk); #1; req = 1'b0;            // E0
        @(posedge clk); #1;                        // E1
        req = 1'b1; mul_op = 1'b0; func = 6'h12;   // dependent MFLO
        nstall = 0; vcnt = 0; vres = 32'd0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (result_valid) begin vcnt++; vres = mul_result; end
            if (stall) nstall++;
        end while (stall && n < 60);
        checks++; if (nstall !== 32) begin errors++; $display("FAIL mflo_stall_cycles: got %0d want 32", nstall); end
        checks++; if (lo !== m_lo)   begin errors++; $display("FAIL mul_lo_unchanged: got %h want %h", lo, m_lo); end
        checks++; if (hi !== m_hi)   begin errors++; $display("FAIL mul_hi_unchanged: got %h want %h", hi, m_hi); end
        checks++; if (vres !== m_res) begin errors++; $display("FAIL mul_result: got %h want %h", vres, m_res); end
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_pulse_width: got %b want 0", result_valid); end
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL mul_valid_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_flush();
        int bc, vc; logic [31:0] vr, t;
        t = $urandom;
        model_op(1'b0, 6'h11, t, 32'd0);
        do_op(1'b0, 6'h11, t, 32'd0, bc, vc, vr);
        t = $urandom;
        model_op(1'b0, 6'h13, t, 32'd0);
        do_op(1'b0, 6'h13, t, 32'd0, bc, vc, vr);
        // MULTU in flight, flushed at E10
        @(negedge clk); req = 1'b1; mul_op = 1'b0; func = 6'h19; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1; req = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        repeat (30) @(negedge clk);
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL flush_hi_kept: got %h want %h", hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL flush_lo_kept: got %h want %h", lo, m_lo); end
        // flush and req on the same edge: the op is dropped
        @(negedge clk); req = 1'b1; mul_op = 1'b0; func = 6'h11; a = ~m_hi; flush = 1'b1;
        @(posedge clk); #1; req = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL flush_beats_req: got %h want %h", hi, m_hi); end
        // Fresh MULTU runs to completion
        model_op(1'b0, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(1'b0, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, vc, vr);
        checks++; if (bc !== 33)   begin errors++; $display("FAIL multu_after_flush_busy: got %0d want 33", bc); end
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL multu_after_flush_hi: got %h want %h", hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL multu_after_flush_lo: got %h want %h", lo, m_lo); end
    endtask

    task automatic test_div();
        int bc, vc; logic [31:0] vr, x, y; logic [5:0] f;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0: begin f = 6'h1A; x = -32'sd7;       y = 32'd2;         end
                1: begin f = 6'h1B; x = 32'd5;         y = 32'd0;         end
                2: begin f = 6'h1A; x = -32'sd9;       y = 32'd0;         end
                3: begin f = 6'h1A; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                4: begin f = 6'h1A; x = 32'd100;       y = -32'sd7;       end
                default: begin
                    f = ($urandom_range(0, 1) == 0) ? 6'h1A : 6'h1B;
                    x = $urandom;
                    y = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
                end
            endcase
            model_op(1'b0, f, x, y);
            do_op(1'b0, f, x, y, bc, vc, vr);
            checks++; if (bc !== (m_fsm ? 33 : 0)) begin errors++; $display("FAIL div%0d_busy: got %0d want %0d", i, bc, m_fsm ? 33 : 0); end
            checks++; if (lo !== m_lo) begin errors++; $display("FAIL div%0d_lo a=%h b=%h: got %h want %h", i, x, y, lo, m_lo); end
            checks++; if (hi !== m_hi) begin errors++; $display("FAIL div%0d_hi a=%h b=%h: got %h want %h", i, x, y, hi, m_hi); end
        end
    endtask

    task automatic test_random();
        int bc, vc; logic [31:0] vr, x, y; logic [5:0] f; logic mo; int k;
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 11);
            case (k)
                0:  begin mo = 1'b0; f = 6'h18; end
                1:  begin mo = 1'b0; f = 6'h19; end
                2:  begin mo = 1'b1; f = 6'h00; end
                3:  begin mo = 1'b1; f = 6'h01; end
                4:  begin mo = 1'b1; f = 6'h02; end
                5:  begin mo = 1'b1; f = 6'h04; end
                6:  begin mo = 1'b1; f = 6'h05; end
                7:  begin mo = 1'b0; f = 6'h11; end
                8:  begin mo = 1'b0; f = 6'h13; end
                9:  begin mo = 1'b0; f = 6'h20; end   // not a HI/LO op
                10: begin mo = 1'b1; f = 6'h03; end   // unused SPECIAL2 code
                default: begin mo = 1'b0; f = 6'h10; end
            endcase
            x = $urandom;
            y = $urandom;
            model_op(mo, f, x, y);
            do_op(mo, f, x, y, bc, vc, vr);
            checks++; if (bc !== (m_fsm ? 33 : 0)) begin errors++; $display("FAIL rnd%0d_busy: got %0d want %0d", i, bc, m_fsm ? 33 : 0); end
            checks++; if (hi !== m_hi) begin errors++; $display("FAIL rnd%0d_hi op=%b/%h: got %h want %h", i, mo, f, hi, m_hi); end
            checks++; if (lo !== m_lo) begin errors++; $display("FAIL rnd%0d_lo op=%b/%h: got %h want %h", i, mo, f, lo, m_lo); end
            checks++; if (vc !== (m_valid ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_valid_count: got %0d want %0d", i, vc, m_valid ? 1 : 0); end
            checks++; if (mul_result !== m_res) begin errors++; $display("FAIL rnd%0d_mul_result: got %h want %h", i, mul_result, m_res); end
        end
    endtask

    task automatic test_nrst_mid();
        int bc, vc; logic [31:0] vr;
        @(negedge clk); req = 1'b1; mul_op = 1'b1; func = 6'h04; a = 32'd123; b = 32'd456;
        @(posedge clk); #1; req = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk); #2 nrst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL nrst_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'd0)         begin errors++; $display("FAIL nrst_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)         begin errors++; $display("FAIL nrst_lo: got %h want 0", lo); end
        checks++; if (mul_result !== 32'd0) begin errors++; $display("FAIL nrst_mul_result: got %h want 0", mul_result); end
        @(negedge clk); nrst = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
        model_op(1'b1, 6'h04, 32'd2, 32'd3);
        do_op(1'b1, 6'h04, 32'd2, 32'd3, bc, vc, vr);
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL msub_after_reset_hi: got %h want %h", hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL msub_after_reset_lo: got %h want %h", lo, m_lo); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_flush();
        test_div();
        test_random();
        test_nrst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
